// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the CPU memory port: access-size codes, the
//   arbiter FSM state encoding and the alignment rule. The LSU uses the
//   same align_ok() so both sides reject exactly the same accesses.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // True when an access of 'size' at an address ending in 'addr_lo' is legal.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            SIZE_WORD: ok = (addr_lo == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker, purely combinational.
//   req  : request vector, bit i = port i wants the resource
//   last : index of the port served most recently
//   gnt  : one-hot winner, 00 when nobody requests
// On contention the port that was not served last wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single CPU memory port between port 0 (CPU core) and port 1
//   (loader/debug master). One transaction at a time, round-robin between
//   ports, fixed read latency, misaligned/illegal accesses rejected before
//   they reach memory.
//
//   clk, reset          : clock (rising edge), async active-low reset
//   req/we[1:0]         : per-port request (held until done) and store flag
//   size0/1, addr0/1,
//   wdata0/1            : per-port access fields
//   gnt[1:0]            : one-hot current owner, 00 when idle
//   done[1:0]           : one-cycle completion pulse to the owner
//   err                 : with done, 1 = access rejected, memory untouched
//   rdata               : load data, updated only by successful loads
//   mem_clk             : memory write strobe, one cycle per store
//   mem_size/addr/wdata : access presented to memory
//   mem_rdata           : load data returned by memory
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no owner; pick a winner and latch its fields onto mem_*
//   ACCESS | alignment check; stores strobe mem_clk here
//   WAIT   | load in flight, lat_cnt counts down to data capture
//   RESP   | done pulse to owner, owner becomes 'last', release gnt
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [1:0]    size0,
    input  logic [1:0]    size1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_clk,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // WAIT spends READ_LAT cycles: lat_cnt runs READ_LAT-1 .. 0.
    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    state_t        state_q,     state_d;
    logic [1:0]    gnt_q,       gnt_d;
    logic          err_q,       err_d;
    logic [DW-1:0] rdata_q,     rdata_d;
    logic [1:0]    mem_size_q,  mem_size_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          we_q,        we_d;
    logic [3:0]    lat_cnt_q,   lat_cnt_d;
    logic          last_q,      last_d;

    logic [1:0]    pick;
    logic          acc_ok;

    rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (pick)
    );

    assign acc_ok = align_ok(mem_size_q, mem_addr_q[1:0]);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        lat_cnt_d   = lat_cnt_q;
        last_d      = last_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d       = pick;
                    mem_size_d  = pick[1] ? size1  : size0;
                    mem_addr_d  = pick[1] ? addr1  : addr0;
                    mem_wdata_d = pick[1] ? wdata1 : wdata0;
                    we_d        = pick[1] ? we[1]  : we[0];
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!acc_ok) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (we_q) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    err_d     = 1'b0;
                    lat_cnt_d = LAT_M1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
            lat_cnt_q   <= 4'd0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            lat_cnt_q   <= lat_cnt_d;
            last_q      <= last_d;
        end
    end

    // Strobe and done decode straight from the state flops, so an async
    // reset kills both in the same instant it returns the FSM to IDLE.
    assign mem_clk   = (state_q == ST_ACCESS) && we_q && acc_ok;
    assign done      = (state_q == ST_RESP) ? gnt_q : 2'b00;
    assign gnt       = gnt_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
